// File: rtl/bsg_fifo_multi_rr_deq.sv
// Round-robin dequeue from a multi-lane FIFO into one registered stream with source id.
// Optional per-lane grant counters are enabled with BSG_FIFO_MULTI_RR_DEQ_PERF_EN.
`ifndef BSG_SAFE_CLOG2
`define BSG_SAFE_CLOG2(x) (((x) == 1) ? 1 : $clog2(x))
`endif

module bsg_fifo_multi_rr_deq #(
  parameter int width_p     = 32,
  parameter int fifos_p     = 4,
  parameter int lg_fifos_lp = `BSG_SAFE_CLOG2(fifos_p)
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [fifos_p-1:0]              v_i,
  input  logic [fifos_p-1:0][width_p-1:0] data_i,
  output logic [fifos_p-1:0]              yumi_o,
  output logic                            v_o,
  output logic [width_p-1:0]              data_o,
  output logic [lg_fifos_lp-1:0]          id_o,
  input  logic                            ready_and_i
`ifdef BSG_FIFO_MULTI_RR_DEQ_PERF_EN
  ,
  output logic [fifos_p-1:0][15:0]        grant_cnt_o
`endif
);

  // valid/ready: a beat leaves on v_o & ready_and_i; a lane is dequeued on
  // yumi_o, which only fires when the output register is empty or draining.
  logic                   v_q, v_d;
  logic [width_p-1:0]     data_q, data_d;
  logic [lg_fifos_lp-1:0] id_q, id_d;
  logic [lg_fifos_lp-1:0] last_q, last_d;
  logic [lg_fifos_lp-1:0] grant_idx;
  logic                   load_en;

  // last_q + n with n in 1..fifos_p never reaches 2*fifos_p, so one subtract wraps it.
  function automatic logic [lg_fifos_lp-1:0] wrap_idx(input int n);
    return (n >= fifos_p) ? lg_fifos_lp'(n - fifos_p) : lg_fifos_lp'(n);
  endfunction

  // Scan farthest-first so the nearest valid lane after last_q wins.
  always_comb begin
    grant_idx = '0;
    for (int i = fifos_p; i >= 1; i--) begin
      if (v_i[wrap_idx(int'(last_q) + i)]) grant_idx = wrap_idx(int'(last_q) + i);
    end
  end

  assign load_en = (|v_i) & (~v_q | ready_and_i);

  always_comb begin
    for (int k = 0; k < fifos_p; k++) begin
      yumi_o[k] = load_en & ~reset_i & (grant_idx == lg_fifos_lp'(k));
    end
  end

  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (load_en) begin
      v_d    = 1'b1;
      data_d = data_i[grant_idx];
      id_d   = grant_idx;
      last_d = grant_idx;
    end else if (ready_and_i) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= lg_fifos_lp'(fifos_p - 1);
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

  assign v_o    = v_q;
  assign data_o = data_q;
  assign id_o   = id_q;

`ifdef BSG_FIFO_MULTI_RR_DEQ_PERF_EN
  logic [fifos_p-1:0][15:0] cnt_q;

  for (genvar g = 0; g < fifos_p; g++) begin : g_cnt
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
        cnt_q[g] <= '0;
      end else if (yumi_o[g] && (cnt_q[g] != 16'hFFFF)) begin
        cnt_q[g] <= cnt_q[g] + 16'd1;
      end
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_bsg_fifo_multi_rr_deq.sv
// Directed table-driven bench for bsg_fifo_multi_rr_deq (4 lanes x 32 bits),
// plus a hand-written asynchronous reset-during-stall sequence.
module tb_bsg_fifo_multi_rr_deq;

  localparam int W = 32;
  localparam int F = 4;

  logic            clk;
  logic            reset_i;
  logic [F-1:0]    v_i;
  logic [F-1:0][W-1:0] data_i;
  logic [F-1:0]    yumi_o;
  logic            v_o;
  logic [W-1:0]    data_o;
  logic [1:0]      id_o;
  logic            ready_and_i;
`ifdef BSG_FIFO_MULTI_RR_DEQ_PERF_EN
  logic [F-1:0][15:0] grant_cnt_o;
`endif

  bsg_fifo_multi_rr_deq #(.width_p(W), .fifos_p(F)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .v_i         (v_i),
    .data_i      (data_i),
    .yumi_o      (yumi_o),
    .v_o         (v_o),
    .data_o      (data_o),
    .id_o        (id_o),
    .ready_and_i (ready_and_i)
`ifdef BSG_FIFO_MULTI_RR_DEQ_PERF_EN
    ,
    .grant_cnt_o (grant_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic        rdy;
    logic [31:0] base;
    logic [3:0]  exp_yumi;
    logic        exp_v;
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [3:0] v, input logic rdy, input logic [31:0] base,
                     input logic [3:0] ey, input logic ev, input logic [1:0] eid, input logic [31:0] ed);
    vec_t t;
    t.rst = rst; t.v = v; t.rdy = rdy; t.base = base;
    t.exp_yumi = ey; t.exp_v = ev; t.exp_id = eid; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  task automatic drive_data(input logic [31:0] base);
    for (int k = 0; k < F; k++) data_i[k] = base + 32'(k);
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = '0;
    ready_and_i = 1'b0;
    drive_data(32'h0);

    // stimulus table: {rst, v_i, ready, data base} -> {yumi, v_o, id_o, data_o after edge}
    add(1, 4'b0001, 1, 32'h00A,  4'b0001, 1, 0, 32'h00A);
    add(0, 4'b0000, 1, 32'h000,  4'b0000, 0, 0, 32'h00A);
    add(1, 4'b1111, 1, 32'h100,  4'b0001, 1, 0, 32'h100);
    add(0, 4'b1111, 1, 32'h200,  4'b0010, 1, 1, 32'h201);
    add(0, 4'b1111, 1, 32'h300,  4'b0100, 1, 2, 32'h302);
    add(0, 4'b1111, 1, 32'h400,  4'b1000, 1, 3, 32'h403);
    add(0, 4'b1111, 1, 32'h500,  4'b0001, 1, 0, 32'h500);
    add(0, 4'b1111, 1, 32'h600,  4'b0010, 1, 1, 32'h601);
    add(0, 4'b1111, 1, 32'h700,  4'b0100, 1, 2, 32'h702);
    add(0, 4'b1111, 1, 32'h800,  4'b1000, 1, 3, 32'h803);
    add(0, 4'b0101, 1, 32'h900,  4'b0001, 1, 0, 32'h900);
    add(0, 4'b0101, 1, 32'hA00,  4'b0100, 1, 2, 32'hA02);
    for (int s = 0; s < 5; s++)
      add(0, 4'b1111, 0, 32'hB00, 4'b0000, 1, 2, 32'hA02);
    add(0, 4'b1111, 1, 32'hC00,  4'b1000, 1, 3, 32'hC03);
    add(0, 4'b0100, 1, 32'hD00,  4'b0100, 1, 2, 32'hD02);
    add(0, 4'b0100, 1, 32'hE00,  4'b0100, 1, 2, 32'hE02);
    add(0, 4'b0100, 1, 32'hF00,  4'b0100, 1, 2, 32'hF02);
    add(0, 4'b1010, 0, 32'h1000, 4'b0000, 1, 2, 32'hF02);
    add(0, 4'b1010, 1, 32'h1100, 4'b1000, 1, 3, 32'h1103);
    add(0, 4'b0000, 0, 32'h1200, 4'b0000, 1, 3, 32'h1103);
    add(0, 4'b0000, 1, 32'h1300, 4'b0000, 0, 3, 32'h1103);
    add(0, 4'b0001, 0, 32'h1400, 4'b0001, 1, 0, 32'h1400);
    add(0, 4'b0010, 0, 32'h1500, 4'b0000, 1, 0, 32'h1400);
    add(0, 4'b1001, 1, 32'h1600, 4'b1000, 1, 3, 32'h1603);
    add(0, 4'b1001, 1, 32'h1700, 4'b0001, 1, 0, 32'h1700);

    repeat (2) @(posedge clk);

    // reset state before the table starts
    @(negedge clk);
    check("reset v_o", 32'(v_o), 32'h0);
    check("reset data_o", data_o, 32'h0);
    check("reset id_o", 32'(id_o), 32'h0);
    check("reset yumi_o", 32'(yumi_o), 32'h0);
    reset_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst) begin
        reset_i = 1'b1;
        #1;
        reset_i = 1'b0;
      end
      v_i = vecs[i].v;
      ready_and_i = vecs[i].rdy;
      drive_data(vecs[i].base);
      #1;
      check($sformatf("vec%0d yumi_o", i), 32'(yumi_o), 32'(vecs[i].exp_yumi));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d v_o", i), 32'(v_o), 32'(vecs[i].exp_v));
      check($sformatf("vec%0d id_o", i), 32'(id_o), 32'(vecs[i].exp_id));
      check($sformatf("vec%0d data_o", i), data_o, vecs[i].exp_data);
    end

    // reset asserted mid-stall: beat is dropped before the next edge
    @(negedge clk);
    v_i = 4'b1111;
    ready_and_i = 1'b0;
    drive_data(32'h2000);
    #1;
    check("stall yumi_o", 32'(yumi_o), 32'h0);
    @(posedge clk);
    #1;
    check("stall v_o", 32'(v_o), 32'h1);
    #2;
    reset_i = 1'b1;
    #1;
    check("async rst v_o", 32'(v_o), 32'h0);
    check("async rst data_o", data_o, 32'h0);
    check("async rst id_o", 32'(id_o), 32'h0);
    check("async rst yumi_o", 32'(yumi_o), 32'h0);
`ifdef BSG_FIFO_MULTI_RR_DEQ_PERF_EN
    check("async rst grant_cnt", 32'(|grant_cnt_o), 32'h0);
`endif
    @(negedge clk);
    ready_and_i = 1'b1;
    #1;
    check("held rst yumi_o", 32'(yumi_o), 32'h0);
    @(posedge clk);
    #1;
    check("held rst v_o", 32'(v_o), 32'h0);

    @(negedge clk);
    reset_i = 1'b0;
    #1;
    check("post rst yumi_o", 32'(yumi_o), 32'b0001);
    @(posedge clk);
    #1;
    check("post rst v_o", 32'(v_o), 32'h1);
    check("post rst id_o", 32'(id_o), 32'h0);
    check("post rst data_o", data_o, 32'h2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_fifo_multi_rr_deq.md
BSG_FIFO_MULTI_RR_DEQ -- requirements
Module: bsg_fifo_multi_rr_deq

Interface
REQ-001 SHALL have parameter width_p, default 32, payload width per FIFO lane.
REQ-002 SHALL have parameter fifos_p, default 4, number of upstream FIFO lanes; legal range 1..16.
REQ-003 SHALL have parameter lg_fifos_lp, default `BSG_SAFE_CLOG2(fifos_p), id width.
REQ-004 SHALL have port clk_i  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port v_i  input  fifos_p  per-lane valid from the multi-FIFO.
REQ-007 SHALL have port data_i  input  fifos_p x width_p  per-lane head data.
REQ-008 SHALL have port yumi_o  output  fifos_p  one-hot-or-zero dequeue to the multi-FIFO.
REQ-009 SHALL have port v_o  output  1  merged-stream valid.
REQ-010 SHALL have port data_o  output  width_p  merged-stream data.
REQ-011 SHALL have port id_o  output  lg_fifos_lp  source-lane index of data_o.
REQ-012 SHALL have port ready_and_i  input  1  downstream ready.

Function
REQ-013 SHALL hold one output register {v_r, data_r, id_r} driving v_o/data_o/id_o directly.
REQ-014 SHALL define load_en = (|v_i) & (~v_r | ready_and_i).
REQ-015 SHALL select grant index g as first lane with v_i set, scanning last_r+1, last_r+2, ... modulo fifos_p.
REQ-016 SHALL assert yumi_o[g] only when load_en; all other yumi_o bits 0; yumi_o never multi-hot.
REQ-017 SHALL never assert yumi_o[k] while v_i[k]=0.
REQ-018 SHALL on load_en capture data_r<=data_i[g], id_r<=g, v_r<=1, last_r<=g on the same edge.
REQ-019 SHALL on ~load_en with v_r & ready_and_i clear v_r; data_r/id_r hold.
REQ-020 SHALL hold v_r, data_r, id_r, last_r stable while v_r & ~ready_and_i (no drop, no overwrite).
REQ-021 SHALL give latency 1 cycle yumi_o -> v_o, sustained throughput 1 beat/cycle with ready_and_i=1.
REQ-022 SHALL, with a single lane valid, grant it every cycle regardless of last_r.
REQ-023 SHALL guarantee each continuously valid lane a grant within fifos_p loads.
REQ-024 SHALL with fifos_p=1 reduce to a 1-entry pipe register; id_o constant 0.
REQ-025 SHALL wrap last_r from fifos_p-1 to 0 with no out-of-range index for non-power-of-2 fifos_p.

Reset
REQ-026 SHALL on reset_i assert, asynchronously: v_r=0, data_r=0, id_r=0, last_r=fifos_p-1 (lane 0 first priority).
REQ-027 SHALL force yumi_o=0 while reset_i is high.
REQ-028 SHALL discard any in-flight beat in data_r when reset asserts mid-stall; no yumi_o is retracted.

Configuration
REQ-029 SHALL honour macro BSG_FIFO_MULTI_RR_DEQ_PERF_EN.
REQ-030 SHALL, when defined, add output grant_cnt_o (fifos_p x 16): per-lane saturating-at-16'hFFFF count of yumi_o assertions, reset to 0.
REQ-031 SHALL, when undefined, omit grant_cnt_o and its counters; all other behaviour identical.

Verification
REQ-032 SHALL cover: after reset, v_i=4'b0001, data_i[0]=32'hA, ready_and_i=1 -> yumi_o=4'b0001 same cycle; next cycle v_o=1, data_o=32'hA, id_o=0.
REQ-033 SHALL cover: v_i=4'b1111 held, ready_and_i=1, 8 cycles -> id_o sequence 0,1,2,3,0,1,2,3.
REQ-034 SHALL cover: v_o=1 id_o=2, ready_and_i=0 for 5 cycles with v_i=4'b1111 -> yumi_o=0 throughout, data_o/id_o unchanged; on ready_and_i=1 next id_o=3.
REQ-035 SHALL cover: last grant 3, v_i=4'b0101 -> grant lane 0 then lane 2 (wrap-around skip).
REQ-036 SHALL cover: random v_i/ready_and_i, 100k cycles, bsg_fifo_1r1w_small_hardened_multi upstream with {id,seq} data -> per-lane in-order, no loss/duplication, id_o equals data_o upper bits, yumi_o one-hot-or-zero.
REQ-037 SHALL cover: reset_i asserted mid-stall with v_o=1 -> v_o=0 before next rising edge; with PERF_EN, grant_cnt_o all 0.
